uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter (DATA_BITS-wide data_in, edge-sensitive wr_en, Tx_busy status) among NUM_REQ byte requesters using round-robin arbitration.
- Sequences each transfer: load data, pulse write, wait for the transmitter to start and finish, then acknowledge the requester.
- Sits between bus-side producers (master/slave debug or bridge ports) and the UART transmit path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, byte width; must match the transmitter.
- BUSY_TIMEOUT, 16, clk_50m cycles allowed between wr pulse and tx_busy rising before abort.
- IDW, $clog2(NUM_REQ), width of requester index (localparam, min 1).

Ports:
- clk_50m  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level; held until its ack.
- req_data  in  NUM_REQ*DATA_BITS  packed bytes, requester i at [i*DATA_BITS +: DATA_BITS]; stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle pulse: the requester's byte is done.
- err_timeout  out  1  one-cycle pulse, same cycle as the aborting ack.
- tx_data  out  DATA_BITS  to transmitter data_in.
- tx_wr_en  out  1  to transmitter wr_en; one-cycle high pulse.
- tx_busy  in  1  from transmitter Tx_busy.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  IDW  index of the current or last owner.

Behaviour:
- Reset values: ack=0, err_timeout=0, tx_data=0, tx_wr_en=0, busy=0, grant_id=0, rr pointer=NUM_REQ-1 so requester 0 has first priority, state=IDLE. All outputs are registered.
- IDLE:
  - Grant only if |req and tx_busy==0. Covers a transmitter that is not reset and still busy after our reset.
  - Winner is the first set req bit scanning from (ptr+1) mod NUM_REQ upward with wrap.
  - On grant: latch grant_id, latch tx_data from req_data[winner], go to LOAD.
- LOAD (1 cycle): tx_wr_en=1, clear the timeout counter, go to WAIT_BUSY. tx_wr_en is high only in LOAD.
- WAIT_BUSY:
  - tx_busy==1 -> WAIT_DONE.
  - Otherwise the counter increments. At BUSY_TIMEOUT-1 -> DONE with the abort flag set.
- WAIT_DONE: tx_busy==0 -> DONE. No timeout here; frame length is baud-dependent.
- DONE (1 cycle): ack[grant_id]=1, err_timeout=abort flag, ptr<=grant_id, clear the abort flag, go to IDLE.
- tx_data holds from grant until the next grant. It is never changed while the transmitter may be sampling.
- Latency: req seen in IDLE at cycle t -> tx_wr_en high at t+1 -> ack at least 3 cycles after t+1 (one frame plus 2 cycles typical).
- Back-to-back: after DONE, IDLE may grant the following cycle. Minimum gap between tx_wr_en pulses is 4 cycles, which guarantees a wr_en low phase for the edge detector.
- Requester drops req mid-transfer: the transfer still completes and ack still pulses; the dropped request does not affect other requesters.
- Simultaneous requests: exactly one grant. After requester k is served, it has lowest priority on the next arbitration.
- Reset mid-transfer: immediate return to reset values next edge; no ack. Any byte already in the transmitter finishes on its own. IDLE waits for tx_busy==0 before the next grant.
- Single-bit req with NUM_REQ=1 degenerates to a pass-through sequencer; ptr stays 0.

Optional Feature:
- Macro: UART_TX_SCHED_HDR_EN.
- Defined: each grant sends two bytes.
  - Header byte first, from states HDR_LOAD/HDR_WAIT_BUSY/HDR_WAIT_DONE mirroring LOAD/WAIT_BUSY/WAIT_DONE: {4'hA, zero-extended grant_id in the low nibble} for DATA_BITS=8.
  - Then the payload byte.
  - ack pulses once after the payload.
  - A header timeout skips the payload, acks, and asserts err_timeout.
- Undefined: single payload byte per grant as above; the header states are not present.

Decomposition:
- Package uart_tx_sched_pkg: state encoding constants (IDLE, LOAD, WAIT_BUSY, WAIT_DONE, DONE, HDR_*), header nibble constant 4'hA.
- Sub-module rr_arbiter: combinational round-robin pick (req, ptr -> valid, winner index). It is reusable by other shared bus resources.
- The FSM, counter and registers stay in uart_tx_scheduler.

Test Plan:
- Single request: req=4'b0010, data1=8'h5A, model transmitter busy for 100 cycles -> tx_data=8'h5A, one tx_wr_en pulse one cycle after req, ack=4'b0010 once, err_timeout=0.
- Contention: req=4'b1111 held, data i=8'h10+i -> grant order 0,1,2,3,0; four distinct tx_wr_en pulses; tx_data never changes during busy.
- Fairness: req0 and req2 continuously asserted -> alternating 0,2,0,2 acks.
- Timeout: tx_busy tied 0, req=4'b0001 -> ack[0] and err_timeout pulse together 16 cycles after tx_wr_en; next request is granted.
- Reset: assert rst during WAIT_DONE with tx_busy=1 -> outputs reset, no ack. Then hold tx_busy=1 for 20 cycles with req pending -> no tx_wr_en until tx_busy falls.
- UART_TX_SCHED_HDR_EN defined, req=4'b0100, data=8'hC3 -> bytes 8'hA2 then 8'hC3, one ack[2].

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional feature macro: UART_TX_SCHED_HDR_EN (adds the header-byte states).
package uart_tx_sched_pkg;

   // FSM state encoding; the header states exist only when the header feature is built in
   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      LOAD          = 3'd1,
      WAIT_BUSY     = 3'd2,
      WAIT_DONE     = 3'd3,
      DONE          = 3'd4
`ifdef UART_TX_SCHED_HDR_EN
      , HDR_LOAD    = 3'd5,
      HDR_WAIT_BUSY = 3'd6,
      HDR_WAIT_DONE = 3'd7
`endif
   } state_e;

   // Upper nibble that marks a header byte on the wire
   localparam logic [3:0] HDR_NIBBLE = 4'hA;

   // Header byte: marker nibble above the requester index
   function automatic logic [7:0] hdr_byte(input logic [3:0] id);
      return {HDR_NIBBLE, id};
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: scans from ptr+1 upward with wrap and
// returns the first requesting index. Reusable for any shared resource.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic           valid_o,
   output logic [IDW-1:0] winner_o
);

   // Priority scan starting just after the last served requester
   always_comb begin
      logic [IDW-1:0] idx_s;
      valid_o  = 1'b0;
      winner_o = '0;
      idx_s    = '0;
      for (int k = 1; k <= N; k++) begin
         idx_s = IDW'((int'(ptr_i) + k) % N);
         if (!valid_o && req_i[idx_s]) begin
            valid_o  = 1'b1;
            winner_o = idx_s;
         end else begin
            valid_o  = valid_o;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters (round robin).
// Each grant: load tx_data, pulse tx_wr_en, wait for tx_busy to rise and
// fall (with a start timeout), then pulse ack for the owner.
// Optional feature macro: UART_TX_SCHED_HDR_EN -- a header byte
// {4'hA, grant_id} is sent before each payload byte.
module uart_tx_scheduler
   import uart_tx_sched_pkg::*;
#(
   parameter  int NUM_REQ      = 4,
   parameter  int DATA_BITS    = 8,
   parameter  int BUSY_TIMEOUT = 16,
   localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clk_50m,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         err_timeout,
   output logic [DATA_BITS-1:0]         tx_data,
   output logic                         tx_wr_en,
   input  logic                         tx_busy,
   output logic                         busy,
   output logic [IDW-1:0]               grant_id
);

   // Counter only needs to reach BUSY_TIMEOUT-2: the final WAIT_BUSY cycle
   // decides the abort, so the aborting ack lands BUSY_TIMEOUT cycles after wr.
   localparam int CW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 2);

   state_e                 state_q, state_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic [IDW-1:0]         grant_q, grant_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   wr_q, wr_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   abort_q, abort_d;
`ifdef UART_TX_SCHED_HDR_EN
   logic [DATA_BITS-1:0]   pay_q, pay_d;
   logic [DATA_BITS-1:0]   hdr_s;
`endif

   logic                   rr_valid_s;
   logic [IDW-1:0]         rr_winner_s;
   logic [DATA_BITS-1:0]   req_bytes_s [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes_s[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
   end

   rr_arbiter #(
      .N   (NUM_REQ),
      .IDW (IDW)
   ) u_arb (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .valid_o  (rr_valid_s),
      .winner_o (rr_winner_s)
   );

`ifdef UART_TX_SCHED_HDR_EN
   // Header byte for the requester currently winning arbitration
   always_comb begin
      hdr_s = DATA_BITS'(hdr_byte(4'(rr_winner_s)));
   end
`endif

   // Next-state logic and next values of every registered output
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
`ifdef UART_TX_SCHED_HDR_EN
      pay_d   = pay_q;
`endif
      case (state_q)
         IDLE: begin
            // A transmitter left busy across our reset must finish first
            if (rr_valid_s && !tx_busy) begin
               grant_d = rr_winner_s;
`ifdef UART_TX_SCHED_HDR_EN
               data_d  = hdr_s;
               pay_d   = req_bytes_s[rr_winner_s];
               state_d = HDR_LOAD;
`else
               data_d  = req_bytes_s[rr_winner_s];
               state_d = LOAD;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               abort_d = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_DONE: begin
            // Frame length depends on baud rate, so no timeout here
            if (!tx_busy) begin
               state_d = DONE;
            end else begin
               state_d = WAIT_DONE;
            end
         end
         DONE: begin
            ptr_d   = grant_q;
            abort_d = 1'b0;
            state_d = IDLE;
         end
`ifdef UART_TX_SCHED_HDR_EN
         HDR_LOAD: begin
            cnt_d   = '0;
            state_d = HDR_WAIT_BUSY;
         end
         HDR_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = HDR_WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               // Header never started: skip the payload and report
               abort_d = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HDR_WAIT_DONE: begin
            // Payload only replaces tx_data once the transmitter is idle
            if (!tx_busy) begin
               data_d  = pay_q;
               state_d = LOAD;
            end else begin
               state_d = HDR_WAIT_DONE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs follow the state being entered so they are registered
      wr_d   = (state_d == LOAD)
`ifdef UART_TX_SCHED_HDR_EN
               || (state_d == HDR_LOAD)
`endif
               ;
      busy_d = (state_d != IDLE);
      ack_d  = '0;
      if (state_d == DONE) begin
         ack_d[grant_d] = 1'b1;
         err_d          = abort_d;
      end else begin
         err_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= IDW'(NUM_REQ - 1);
         grant_q <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
`ifdef UART_TX_SCHED_HDR_EN
         pay_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
`ifdef UART_TX_SCHED_HDR_EN
         pay_q   <= pay_d;
`endif
      end
   end

   assign ack         = ack_q;
   assign err_timeout = err_q;
   assign tx_data     = data_q;
   assign tx_wr_en    = wr_q;
   assign busy        = busy_q;
   assign grant_id    = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: transmitter model, directed
// scenarios and randomized rounds against a round-robin reference model.
// Honours UART_TX_SCHED_HDR_EN when the DUT is built with it.
module tb_uart_tx_scheduler;
   localparam int NREQ = 4;
   localparam int DB   = 8;

   logic              clk_50m = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*DB-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic              err_timeout;
   logic [DB-1:0]     tx_data;
   logic              tx_wr_en;
   logic              tx_busy;
   logic              busy;
   logic [1:0]        grant_id;

   int compared   = 0;
   int mismatched = 0;

   // transmitter model state
   int         frame_len    = 10;
   bit         tx_dead      = 1'b0;
   bit         force_busy   = 1'b0;
   int         busy_cnt     = 0;
   logic       wr_prev      = 1'b0;
   logic [7:0] held_byte    = 8'h00;
   int         data_changes = 0;
   int         wr_long      = 0;
   logic [7:0] sent_q[$];

   // reference model state
   logic [7:0] exp_q[$];
   logic [3:0] ack_log[$];
   logic       err_log[$];
   int         model_last;

   uart_tx_scheduler #(.NUM_REQ(NREQ), .DATA_BITS(DB), .BUSY_TIMEOUT(16)) dut (
      .clk_50m(clk_50m), .rst(rst), .req(req), .req_data(req_data),
      .ack(ack), .err_timeout(err_timeout), .tx_data(tx_data),
      .tx_wr_en(tx_wr_en), .tx_busy(tx_busy), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk_50m = ~clk_50m;

   // Transmitter: rising wr_en captures tx_data, busy for frame_len cycles
   always @(posedge clk_50m) begin
      wr_prev <= tx_wr_en;
      if (tx_wr_en && wr_prev) wr_long <= wr_long + 1;
      if (busy_cnt > 0 && tx_data !== held_byte) data_changes <= data_changes + 1;
      if (tx_wr_en && !wr_prev) begin
         sent_q.push_back(tx_data);
         held_byte <= tx_data;
         busy_cnt  <= tx_dead ? 0 : frame_len;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end
   assign tx_busy = (busy_cnt > 0) || force_busy;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      model_last = NREQ - 1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".ack"},   32'(ack),         32'd0);
      check({tag, ".err"},   32'(err_timeout), 32'd0);
      check({tag, ".data"},  32'(tx_data),     32'd0);
      check({tag, ".wr"},    32'(tx_wr_en),    32'd0);
      check({tag, ".busy"},  32'(busy),        32'd0);
      check({tag, ".grant"}, 32'(grant_id),    32'd0);
   endtask

   // Round-robin rule: first set bit after the last served index, with wrap
   function automatic int rr_pick(input int last, input logic [3:0] mask);
      for (int k = 1; k <= NREQ; k++) begin
         int c;
         c = (last + k) % NREQ;
         if (mask[c]) return c;
      end
      return -1;
   endfunction

   // Bytes the transmitter should see for one grant
   task automatic push_exp(input int id, input logic [7:0] d);
`ifdef UART_TX_SCHED_HDR_EN
      exp_q.push_back(8'hA0 | 8'(id));
`endif
      exp_q.push_back(d);
   endtask

   task automatic run_acks(input string tag, input int n, input logic [3:0] hold, input int budget);
      int got;
      int waited;
      got    = 0;
      waited = 0;
      while (got < n && waited < budget) begin
         step();
         waited++;
         if (ack !== 4'b0000) begin
            ack_log.push_back(ack);
            err_log.push_back(err_timeout);
            got++;
            req = req & (hold | ~ack);
         end
      end
      check({tag, ".ack_count"}, 32'(got), 32'(n));
   endtask

   task automatic check_sent(input string tag, input int base);
      int n;
      n = sent_q.size() - base;
      check({tag, ".nbytes"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < n && i < exp_q.size(); i++)
         check($sformatf("%s.byte%0d", tag, i), 32'(sent_q[base + i]), 32'(exp_q[i]));
      exp_q.delete();
   endtask

   initial begin
      int base;
      int dc0;
      int cnt;
      logic [3:0] mask;
      logic [3:0] rem;
      int order[$];
      int w;

      rst = 1'b1;
      req = '0;
      req_data = '0;
      model_last = NREQ - 1;
      step(); step(); step();
      check_reset_vals("reset");
      rst = 1'b0;
      step();
      check_reset_vals("post_reset_idle");

      // ---- single request ----
      base = sent_q.size();
      frame_len = 100;
      req_data[15:8] = 8'h5A;
      push_exp(1, 8'h5A);
      req = 4'b0010;
      step();
      check("single.wr_next_cycle", 32'(tx_wr_en), 32'd1);
      check("single.busy", 32'(busy), 32'd1);
      check("single.grant", 32'(grant_id), 32'd1);
      check("single.tx_data", 32'(tx_data), 32'(exp_q[0]));
      ack_log.delete(); err_log.delete();
      run_acks("single", 1, 4'b0000, 1000);
      if (ack_log.size() == 1) begin
         check("single.ack", 32'(ack_log[0]), 32'h2);
         check("single.err", 32'(err_log[0]), 32'd0);
      end
      repeat (3) step();
      check_sent("single", base);

      // ---- contention, all held ----
      do_reset();
      base = sent_q.size();
      dc0 = data_changes;
      frame_len = 12;
      for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
      order.delete();
      for (int j = 0; j < 5; j++) begin
         w = rr_pick(model_last, 4'b1111);
         order.push_back(w);
         push_exp(w, 8'h10 + 8'(w));
         model_last = w;
      end
      ack_log.delete(); err_log.delete();
      req = 4'b1111;
      run_acks("contention", 5, 4'b1111, 2000);
      req = 4'b0000;
      for (int j = 0; j < ack_log.size() && j < 5; j++)
         check($sformatf("contention.ack%0d", j), 32'(ack_log[j]), 32'(4'b0001 << order[j]));
      repeat (4) step();
      check("contention.idle_busy", 32'(busy), 32'd0);
      check_sent("contention", base);
      check("contention.data_stable", 32'(data_changes - dc0), 32'd0);

      // ---- fairness: requesters 0 and 2 always asking ----
      do_reset();
      frame_len = 5;
      ack_log.delete(); err_log.delete();
      req = 4'b0101;
      run_acks("fair", 4, 4'b0101, 2000);
      req = 4'b0000;
      for (int j = 0; j < ack_log.size() && j < 4; j++)
         check($sformatf("fair.ack%0d", j), 32'(ack_log[j]), (j % 2 == 0) ? 32'h1 : 32'h4);
      repeat (4) step();

      // ---- start timeout ----
      do_reset();
      tx_dead = 1'b1;
      req = 4'b0001;
      step();
      check("timeout.wr", 32'(tx_wr_en), 32'd1);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (ack !== 4'b0000) cnt++;
      end
      check("timeout.no_early_ack", 32'(cnt), 32'd0);
      step();
      check("timeout.ack", 32'(ack), 32'h1);
      check("timeout.err", 32'(err_timeout), 32'd1);
      req = 4'b0000;
      tx_dead = 1'b0;
      ack_log.delete(); err_log.delete();
      req = 4'b0010;
      run_acks("after_timeout", 1, 4'b0000, 500);
      if (ack_log.size() == 1) begin
         check("after_timeout.ack", 32'(ack_log[0]), 32'h2);
         check("after_timeout.err", 32'(err_log[0]), 32'd0);
      end
      repeat (3) step();

      // ---- reset mid-transfer ----
      do_reset();
      frame_len = 10;
      req = 4'b0001;
      step();
      repeat (4) step();
      check("rstmid.busy_before", 32'(busy), 32'd1);
      force_busy = 1'b1;
      rst = 1'b1;
      step();
      check_reset_vals("rstmid");
      rst = 1'b0;
      model_last = NREQ - 1;
      cnt = 0;
      w = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tx_wr_en === 1'b1) cnt++;
         if (ack !== 4'b0000) w++;
      end
      check("rstmid.no_wr_while_busy", 32'(cnt), 32'd0);
      check("rstmid.no_ack", 32'(w), 32'd0);
      force_busy = 1'b0;
      ack_log.delete(); err_log.delete();
      run_acks("rstmid_resume", 1, 4'b0000, 500);
      if (ack_log.size() == 1) check("rstmid_resume.ack", 32'(ack_log[0]), 32'h1);
      repeat (3) step();

      // ---- randomized rounds ----
      do_reset();
      for (int r = 0; r < 10; r++) begin
         base = sent_q.size();
         dc0 = data_changes;
         mask = 4'($urandom_range(1, 15));
         frame_len = $urandom_range(2, 15);
         for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'($urandom);
         rem = mask;
         order.delete();
         while (rem != 4'b0000) begin
            w = rr_pick(model_last, rem);
            order.push_back(w);
            push_exp(w, req_data[w*8 +: 8]);
            rem[w] = 1'b0;
            model_last = w;
         end
         ack_log.delete(); err_log.delete();
         req = mask;
         run_acks($sformatf("rand%0d", r), order.size(), 4'b0000, 3000);
         req = 4'b0000;
         for (int j = 0; j < ack_log.size() && j < order.size(); j++)
            check($sformatf("rand%0d.ack%0d", r, j), 32'(ack_log[j]), 32'(4'b0001 << order[j]));
         repeat ($urandom_range(2, 5)) step();
         check_sent($sformatf("rand%0d", r), base);
         check($sformatf("rand%0d.data_stable", r), 32'(data_changes - dc0), 32'd0);
      end

`ifdef UART_TX_SCHED_HDR_EN
      // ---- header feature ----
      do_reset();
      base = sent_q.size();
      frame_len = 8;
      req_data[23:16] = 8'hC3;
      ack_log.delete(); err_log.delete();
      req = 4'b0100;
      run_acks("hdr", 1, 4'b0000, 1000);
      repeat (3) step();
      check("hdr.nbytes", 32'(sent_q.size() - base), 32'd2);
      if (sent_q.size() - base == 2) begin
         check("hdr.byte0", 32'(sent_q[base]), 32'hA2);
         check("hdr.byte1", 32'(sent_q[base + 1]), 32'hC3);
      end
      if (ack_log.size() == 1) check("hdr.ack", 32'(ack_log[0]), 32'h4);
`endif

      check("wr_pulse_width", 32'(wr_long), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
